fwd_sel_ctrl: RTL and testbench
===============================

// Module: fwd_sel_ctrl
// PURPOSE
//  Operand-forwarding controller for the 5-stage integer pipeline. Tracks destination tags of
//  in-flight instructions in EX and MEM and drives the 2-bit select codes consumed by the
//  3-input operand muxes in ID: 00 = regfile (in0), 01 = EX result (in1), 1x = MEM/WB result (in2).
//  Detects load-use hazards, stalls ID one cycle, inserts a bubble and counts stall cycles.
// PARAMETERS
//  REG_AW   5   register address width (32 GPRs, r0 hard-wired zero)
//  CNT_W    32  width of saturating stall-cycle counter
// PORTS
//  clk          in   1      pipeline clock
//  rst          in   1      synchronous reset, active-high
//  id_valid     in   1      instruction present in ID
//  id_rj        in   REG_AW source 1 address
//  id_rk        in   REG_AW source 2 address
//  id_rj_used   in   1      source 1 read by this instruction
//  id_rk_used   in   1      source 2 read by this instruction
//  id_rd        in   REG_AW destination address
//  id_wen       in   1      instruction writes id_rd
//  id_is_load   in   1      instruction is a load (data ready end of MEM)
//  pipe_stall   in   1      downstream stall; freezes tracking
//  flush        in   1      branch/exception kill of ID and EX contents
//  id_ready     out  1      ID may advance into EX this cycle
//  sel_j        out  2      select for operand-j mux
//  sel_k        out  2      select for operand-k mux
//  stall_cnt    out  CNT_W  load-use stall cycles since reset, saturating
// BEHAVIOUR
//  - Clock/reset: one clock; rst synchronous active-high. Reset: ex_v=mem_v=0, stall_cnt=0;
//    combinational outputs therefore sel_j=sel_k=2'b00, id_ready=!pipe_stall.
//  - Tracking entries ex{v,rd,ld}, mem{v,rd,ld}. Entry valid only when wen=1 and rd!=0.
//  - Per source s in {j,k} (combinational, zero latency):
//      hit_ex  = s_used & ex_v  & ex_rd==s  & s!=0
//      hit_mem = s_used & mem_v & mem_rd==s & s!=0
//      sel = hit_ex ? 2'b01 : hit_mem ? 2'b10 : 2'b00. Youngest (EX) wins; 2'b11 never driven.
//  - load_use = id_valid & (hit_ex_j | hit_ex_k) & ex_ld. While load_use, sel for the EX-hit
//    source is don't-care (bubble issued); next cycle the load is in MEM -> sel=2'b10.
//  - id_ready = !pipe_stall & !load_use. id_fire = id_valid & id_ready.
//  - Update each rising edge, priority rst > pipe_stall > normal:
//      pipe_stall=1: ex, mem hold; except flush=1 still clears ex_v.
//      normal: mem <= ex; ex <= id_fire & !flush ? {id_wen&(id_rd!=0), id_rd, id_is_load} : bubble.
//  - flush never clears mem (older instruction commits). flush with load_use: bubble, no count.
//  - stall_cnt += 1 on each cycle with load_use & !pipe_stall & !flush; saturates at all-ones.
//  - rst mid-stall: next cycle all entries invalid, no forwarding, id_ready=!pipe_stall.
// STRUCTURE
//  - Select encodings SEL_RF=2'b00, SEL_EX=2'b01, SEL_MEM=2'b10 and REG_AW belong in the shared
//    CPU_Parameter.vh header, used by both this block and the operand muxes.
//  - One sub-module: fwd_src_match (per-source tag compare -> hit_ex, hit_mem, sel), instanced
//    twice (j, k). Tracking regs, hazard logic and counter stay in top.
// TESTING
//  1 rst=1 two cycles, then id rj=3 used, no producers -> sel_j=00, id_ready=1, stall_cnt=0.
//  2 add r5 (wen) fires; next cycle id rj=5 -> sel_j=01; following cycle (r5 in MEM) rk=5 -> sel_k=10.
//  3 r7 written in EX and MEM both (back-to-back) ; id rj=7 -> sel_j=01 (EX priority), never 11.
//  4 ld r9 fires; next id rk=9 used -> id_ready=0, stall_cnt=1; next cycle sel_k=10, id_ready=1.
//  5 rd=0 with wen=1 in EX, id rj=0 -> sel_j=00, no stall; rj_used=0 with match -> sel_j=00.
//  6 flush with ld r4 in EX and id rj=4: ex cleared, stall_cnt unchanged; pipe_stall=1 holds
//    entries and sel stable; stall_cnt preloaded near max saturates at all-ones.

Source files
------------

// File: rtl/fwd_sel_ctrl_pkg.sv
// Shared operand-forwarding definitions: register address width and
// the 3-input operand mux select encodings used by ID.
package fwd_sel_ctrl_pkg;

  localparam int unsigned REG_AW = 5;

  typedef enum logic [1:0] {
    SEL_RF  = 2'b00,
    SEL_EX  = 2'b01,
    SEL_MEM = 2'b10
  } sel_e;

endpackage

// File: rtl/fwd_src_match.sv
// Per-source tag compare against the EX and MEM destination tags;
// produces the EX-hit flag and the operand mux select (EX beats MEM).
module fwd_src_match
  import fwd_sel_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = fwd_sel_ctrl_pkg::REG_AW
) (
  input  logic [REG_AW-1:0] src,
  input  logic              used,
  input  logic              ex_v,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              mem_v,
  input  logic [REG_AW-1:0] mem_rd,
  output logic              hit_ex,
  output logic [1:0]        sel
);

  logic src_nz;
  logic hit_mem;

  always_comb begin
    src_nz  = (src != '0);
    hit_ex  = used & ex_v  & (ex_rd  == src) & src_nz;
    hit_mem = used & mem_v & (mem_rd == src) & src_nz;
    if (hit_ex) begin
      sel = SEL_EX;
    end else if (hit_mem) begin
      sel = SEL_MEM;
    end else begin
      sel = SEL_RF;
    end
  end

endmodule

// File: rtl/fwd_sel_ctrl.sv
// Operand-forwarding controller: tracks EX/MEM destination tags, drives the
// ID operand mux selects, detects load-use hazards and counts stall cycles.
module fwd_sel_ctrl
  import fwd_sel_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = fwd_sel_ctrl_pkg::REG_AW,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rj,
  input  logic [REG_AW-1:0] id_rk,
  input  logic              id_rj_used,
  input  logic              id_rk_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_wen,
  input  logic              id_is_load,
  input  logic              pipe_stall,
  input  logic              flush,
  output logic              id_ready,
  output logic [1:0]        sel_j,
  output logic [1:0]        sel_k,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              ex_v_q,  ex_v_d;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
  logic              ex_ld_q, ex_ld_d;
  logic              mem_v_q,  mem_v_d;
  logic [REG_AW-1:0] mem_rd_q, mem_rd_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic hit_ex_j, hit_ex_k;
  logic load_use, id_fire;

  fwd_src_match #(.REG_AW(REG_AW)) u_match_j (
    .src    (id_rj),
    .used   (id_rj_used),
    .ex_v   (ex_v_q),
    .ex_rd  (ex_rd_q),
    .mem_v  (mem_v_q),
    .mem_rd (mem_rd_q),
    .hit_ex (hit_ex_j),
    .sel    (sel_j)
  );

  fwd_src_match #(.REG_AW(REG_AW)) u_match_k (
    .src    (id_rk),
    .used   (id_rk_used),
    .ex_v   (ex_v_q),
    .ex_rd  (ex_rd_q),
    .mem_v  (mem_v_q),
    .mem_rd (mem_rd_q),
    .hit_ex (hit_ex_k),
    .sel    (sel_k)
  );

  always_comb begin
    load_use = id_valid & ex_ld_q & (hit_ex_j | hit_ex_k);
    id_ready = ~pipe_stall & ~load_use;
    id_fire  = id_valid & id_ready;

    ex_v_d      = ex_v_q;
    ex_rd_d     = ex_rd_q;
    ex_ld_d     = ex_ld_q;
    mem_v_d     = mem_v_q;
    mem_rd_d    = mem_rd_q;
    stall_cnt_d = stall_cnt_q;

    if (pipe_stall) begin
      // A kill still reaches EX while the rest of the pipe is frozen.
      if (flush) begin
        ex_v_d = 1'b0;
      end
    end else begin
      mem_v_d  = ex_v_q;
      mem_rd_d = ex_rd_q;
      if (id_fire & ~flush) begin
        ex_v_d  = id_wen & (id_rd != '0);
        ex_rd_d = id_rd;
        ex_ld_d = id_is_load;
      end else begin
        ex_v_d  = 1'b0;
        ex_rd_d = '0;
        ex_ld_d = 1'b0;
      end
      if (load_use & ~flush & (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_v_q      <= 1'b0;
      ex_rd_q     <= '0;
      ex_ld_q     <= 1'b0;
      mem_v_q     <= 1'b0;
      mem_rd_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_v_q      <= ex_v_d;
      ex_rd_q     <= ex_rd_d;
      ex_ld_q     <= ex_ld_d;
      mem_v_q     <= mem_v_d;
      mem_rd_q    <= mem_rd_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_sel_ctrl.sv
// Bench for fwd_sel_ctrl: directed vector table, saturation sequence on a
// narrow-counter instance, and random traffic against a pipeline-list model.
module tb_fwd_sel_ctrl;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rj, id_rk, id_rd;
  logic        id_rj_used, id_rk_used;
  logic        id_wen, id_is_load;
  logic        pipe_stall, flush;
  logic        id_ready, id_ready_s;
  logic [1:0]  sel_j, sel_k, sel_j_s, sel_k_s;
  logic [31:0] stall_cnt;
  logic [2:0]  stall_cnt_s;

  int checks = 0;
  int errors = 0;

  fwd_sel_ctrl #(.REG_AW(5), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rj(id_rj), .id_rk(id_rk),
    .id_rj_used(id_rj_used), .id_rk_used(id_rk_used), .id_rd(id_rd),
    .id_wen(id_wen), .id_is_load(id_is_load), .pipe_stall(pipe_stall),
    .flush(flush), .id_ready(id_ready), .sel_j(sel_j), .sel_k(sel_k),
    .stall_cnt(stall_cnt)
  );

  fwd_sel_ctrl #(.REG_AW(5), .CNT_W(3)) dut_s (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rj(id_rj), .id_rk(id_rk),
    .id_rj_used(id_rj_used), .id_rk_used(id_rk_used), .id_rd(id_rd),
    .id_wen(id_wen), .id_is_load(id_is_load), .pipe_stall(pipe_stall),
    .flush(flush), .id_ready(id_ready_s), .sel_j(sel_j_s), .sel_k(sel_k_s),
    .stall_cnt(stall_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    bit rst, vld;
    bit [4:0] rj; bit ju;
    bit [4:0] rk; bit ku;
    bit [4:0] rd; bit wen, ld, ps, fl;
    bit rdy; bit [1:0] sj, sk; int unsigned cnt;
    bit csj, csk, crest;
  } vec_t;

  // Model: in-flight writers, index 0 = EX (youngest), 1 = MEM.
  bit          m_v[2];
  bit [4:0]    m_rd[2];
  bit          m_ld[2];
  int unsigned m_cnt;

  function automatic bit [1:0] ref_sel(bit [4:0] s, bit used);
    if (!used || s == 5'd0) return 2'b00;
    for (int i = 0; i < 2; i++)
      if (m_v[i] && m_rd[i] == s) return (i == 0) ? 2'b01 : 2'b10;
    return 2'b00;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(bit r, bit vld, bit [4:0] rj, bit ju, bit [4:0] rk, bit ku,
                              bit [4:0] rd, bit wen, bit ld, bit ps, bit fl,
                              bit rdy, bit [1:0] sj, bit [1:0] sk, int unsigned cnt,
                              bit csj, bit csk, bit crest);
    vec_t v;
    v.rst = r; v.vld = vld; v.rj = rj; v.ju = ju; v.rk = rk; v.ku = ku;
    v.rd = rd; v.wen = wen; v.ld = ld; v.ps = ps; v.fl = fl;
    v.rdy = rdy; v.sj = sj; v.sk = sk; v.cnt = cnt;
    v.csj = csj; v.csk = csk; v.crest = crest;
    return v;
  endfunction

  task automatic apply(input vec_t v, input bit tbl);
    bit [1:0]    ej, ek;
    bit          lu, hj, hk;
    int unsigned sat;
    @(negedge clk);
    rst = v.rst; id_valid = v.vld;
    id_rj = v.rj; id_rj_used = v.ju; id_rk = v.rk; id_rk_used = v.ku;
    id_rd = v.rd; id_wen = v.wen; id_is_load = v.ld;
    pipe_stall = v.ps; flush = v.fl;
    #1;
    ej = ref_sel(v.rj, v.ju);
    ek = ref_sel(v.rk, v.ku);
    hj = (ej == 2'b01);
    hk = (ek == 2'b01);
    lu = v.vld && m_ld[0] && (hj || hk);
    sat = (m_cnt > 7) ? 7 : m_cnt;
    if (tbl) begin
      if (v.csj) chk("tbl_sel_j", 32'(sel_j), 32'(v.sj));
      if (v.csk) chk("tbl_sel_k", 32'(sel_k), 32'(v.sk));
      if (v.crest) begin
        chk("tbl_id_ready", 32'(id_ready), 32'(v.rdy));
        chk("tbl_stall_cnt", stall_cnt, v.cnt);
        chk("tbl_stall_cnt_small", 32'(stall_cnt_s), v.cnt);
        chk("sel_never_11", 32'(sel_j == 2'b11 || sel_k == 2'b11), 32'd0);
      end
    end else begin
      if (!(lu && hj)) chk("rnd_sel_j", 32'(sel_j), 32'(ej));
      if (!(lu && hk)) chk("rnd_sel_k", 32'(sel_k), 32'(ek));
      chk("sel_never_11", 32'(sel_j == 2'b11 || sel_k == 2'b11), 32'd0);
      chk("rnd_id_ready", 32'(id_ready), 32'(!v.ps && !lu));
      chk("rnd_stall_cnt", stall_cnt, m_cnt);
      chk("rnd_stall_cnt_small", 32'(stall_cnt_s), sat);
    end
    // Advance the model to the state after the coming edge.
    if (v.rst) begin
      m_v[0] = 0; m_v[1] = 0; m_ld[0] = 0; m_ld[1] = 0; m_cnt = 0;
    end else if (v.ps) begin
      if (v.fl) m_v[0] = 0;
    end else begin
      if (lu && !v.fl) m_cnt++;
      m_v[1] = m_v[0]; m_rd[1] = m_rd[0]; m_ld[1] = m_ld[0];
      if (v.vld && !lu && !v.fl) begin
        m_v[0] = v.wen && (v.rd != 5'd0); m_rd[0] = v.rd; m_ld[0] = v.ld;
      end else begin
        m_v[0] = 0; m_rd[0] = 0; m_ld[0] = 0;
      end
    end
  endtask

  vec_t tbl[$];
  vec_t v;

  initial begin
    rst = 1; id_valid = 0; id_rj = 0; id_rk = 0; id_rj_used = 0; id_rk_used = 0;
    id_rd = 0; id_wen = 0; id_is_load = 0; pipe_stall = 0; flush = 0;
    m_v[0] = 0; m_v[1] = 0; m_rd[0] = 0; m_rd[1] = 0; m_ld[0] = 0; m_ld[1] = 0; m_cnt = 0;

    //           rst vld rj ju rk ku rd wen ld ps fl | rdy sj     sk     cnt | csj csk crest
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 2'b00, 2'b00, 0,  0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 2'b00, 2'b00, 0,  1, 1, 1));
    tbl.push_back(mk(0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0,  1, 2'b00, 2'b00, 0,  1, 1, 1));
    tbl.push_back(mk(0, 1, 1, 1, 2, 1, 5, 1, 0, 0, 0,  1, 2'b00, 2'b00, 0,  1, 1, 1));
    tbl.push_back(mk(0, 1, 5, 1, 0, 0, 7, 1, 0, 0, 0,  1, 2'b01, 2'b00, 0,  1, 1, 1));
    tbl.push_back(mk(0, 1, 7, 1, 5, 1, 7, 1, 0, 0, 0,  1, 2'b01, 2'b10, 0,  1, 1, 1));
    tbl.push_back(mk(0, 1, 7, 1, 7, 1, 0, 0, 0, 0, 0,  1, 2'b01, 2'b01, 0,  1, 1, 1));
    tbl.push_back(mk(0, 1, 7, 1, 0, 0, 9, 1, 1, 0, 0,  1, 2'b10, 2'b00, 0,  1, 1, 1));
    tbl.push_back(mk(0, 1, 0, 0, 9, 1,10, 1, 0, 0, 0,  0, 2'b00, 2'b00, 0,  1, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 9, 1,10, 1, 0, 0, 0,  1, 2'b00, 2'b10, 1,  1, 1, 1));
    tbl.push_back(mk(0, 1,10, 0, 0, 0, 0, 1, 0, 0, 0,  1, 2'b00, 2'b00, 1,  1, 1, 1));
    tbl.push_back(mk(0, 1, 0, 1, 0, 1, 4, 1, 1, 0, 0,  1, 2'b00, 2'b00, 1,  1, 1, 1));
    tbl.push_back(mk(0, 1, 4, 1, 0, 0, 0, 0, 0, 0, 1,  0, 2'b00, 2'b00, 1,  0, 1, 1));
    tbl.push_back(mk(0, 1, 4, 1, 0, 0, 6, 1, 0, 0, 0,  1, 2'b10, 2'b00, 1,  1, 1, 1));
    tbl.push_back(mk(0, 1, 6, 1, 0, 0, 8, 1, 0, 1, 0,  0, 2'b01, 2'b00, 1,  1, 1, 1));
    tbl.push_back(mk(0, 1, 6, 1, 0, 0, 8, 1, 0, 1, 0,  0, 2'b01, 2'b00, 1,  1, 1, 1));
    tbl.push_back(mk(0, 1, 6, 1, 6, 1, 0, 0, 0, 0, 0,  1, 2'b01, 2'b01, 1,  1, 1, 1));
    tbl.push_back(mk(0, 1, 6, 1, 0, 0, 0, 0, 0, 1, 1,  0, 2'b10, 2'b00, 1,  1, 1, 1));
    tbl.push_back(mk(0, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0,  1, 2'b10, 2'b00, 1,  1, 1, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 3, 1, 1, 0, 0,  1, 2'b00, 2'b00, 1,  1, 1, 1));
    tbl.push_back(mk(1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0,  0, 2'b00, 2'b00, 1,  0, 1, 1));
    tbl.push_back(mk(0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0,  1, 2'b00, 2'b00, 0,  1, 1, 1));

    foreach (tbl[i]) apply(tbl[i], 1'b1);

    // Repeated load-use stalls: wide counter keeps counting, 3-bit one sticks at 7.
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 1'b0);
    for (int n = 0; n < 10; n++) begin
      apply(mk(0, 1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0), 1'b0);
      apply(mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 1'b0);
      apply(mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 1'b0);
    end
    chk("sat_wide_cnt", stall_cnt, 32'd10);
    chk("sat_small_cnt", 32'(stall_cnt_s), 32'd7);

    for (int n = 0; n < 3000; n++) begin
      v = mk(($urandom % 64) == 0, ($urandom % 4) != 0,
             5'($urandom % 4), 1'($urandom % 2), 5'($urandom % 4), 1'($urandom % 2),
             5'($urandom % 4), 1'($urandom % 2), ($urandom % 3) == 0,
             ($urandom % 6) == 0, ($urandom % 8) == 0,
             1, 0, 0, 0, 0, 0, 0);
      apply(v, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
